// File: rtl/bus_fabric.sv
// bus_fabric
// Registered system-bus interconnect between the CPU data port and NSLAVE
// memory-mapped slaves. A master request is decoded against per-slave
// inclusive address windows. A request/acknowledge handshake then runs with
// the selected slave, and a one-cycle response carries the read data and an
// error flag back to the master.
//
// Optional feature macro: BUS_FABRIC_TIMEOUT_EN
//   defined   : a wait counter ends an unacknowledged access after TIMEOUT
//               cycles with an error response.
//   undefined : the access waits indefinitely for the selected slave's ack,
//               and TIMEOUT is only range-checked.
//
// Ports
//   clock   in   rising-edge system clock
//   nreset  in   asynchronous active-low reset
//   mreq    in   master request, sampled only in IDLE
//   mwrite  in   1 = write, 0 = read
//   maddr   in   master address (AW)
//   mwdata  in   master write data (DW)
//   mready  out  one-cycle response strobe
//   mrdata  out  read data, valid while mready = 1 (DW)
//   merr    out  error flag, valid while mready = 1
//   sreq    out  one-hot slave request (NSLAVE)
//   swrite  out  shared write qualifier
//   saddr   out  shared full address (AW)
//   swdata  out  shared write data (DW)
//   sack    in   slave acknowledges (NSLAVE)
//   srdata  in   packed slave read data, slice i belongs to slave i

module bus_fabric #(
    parameter int                   NSLAVE  = 3,
    parameter int                   AW      = 32,
    parameter int                   DW      = 32,
    parameter logic [NSLAVE*AW-1:0] BASE    = {32'd411700, 32'd206800, 32'd0},
    parameter logic [NSLAVE*AW-1:0] LIMIT   = {32'd411700, 32'd411699, 32'd206799},
    parameter int                   TIMEOUT = 15
) (
    input  logic                 clock,
    input  logic                 nreset,
    input  logic                 mreq,
    input  logic                 mwrite,
    input  logic [AW-1:0]        maddr,
    input  logic [DW-1:0]        mwdata,
    output logic                 mready,
    output logic [DW-1:0]        mrdata,
    output logic                 merr,
    output logic [NSLAVE-1:0]    sreq,
    output logic                 swrite,
    output logic [AW-1:0]        saddr,
    output logic [DW-1:0]        swdata,
    input  logic [NSLAVE-1:0]    sack,
    input  logic [NSLAVE*DW-1:0] srdata
);

    localparam int SW = (NSLAVE > 1) ? $clog2(NSLAVE) : 1;

    if (NSLAVE < 1 || NSLAVE > 16 || TIMEOUT < 2 || TIMEOUT > 255) begin : g_param_check
        $error("bus_fabric: NSLAVE or TIMEOUT out of range");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            write_q, write_d;
    logic            err_q, err_d;
    logic [DW-1:0]   rdata_q, rdata_d;

`ifdef BUS_FABRIC_TIMEOUT_EN
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
    logic [7:0]      cnt_q, cnt_d;
`endif

    logic            hit;
    logic [SW-1:0]   hit_idx;
    logic            ack_sel;
    logic [DW-1:0]   rdata_sel;

    // Address decode. Scanning from the highest index down lets the lowest
    // matching index overwrite the result, so overlapping windows resolve
    // to the lowest slave.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NSLAVE - 1; i >= 0; i--) begin
            if (maddr >= BASE[i*AW +: AW] && maddr <= LIMIT[i*AW +: AW]) begin
                hit     = 1'b1;
                hit_idx = SW'(i);
            end
        end
    end

    // Only the selected slave's ack and data slice matter; other acks are
    // ignored.
    assign ack_sel   = sack[sel_q];
    assign rdata_sel = srdata[int'(sel_q)*DW +: DW];

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        err_d   = err_q;
        rdata_d = rdata_q;
`ifdef BUS_FABRIC_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (mreq) begin
                    addr_d  = maddr;
                    wdata_d = mwdata;
                    write_d = mwrite;
`ifdef BUS_FABRIC_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                    if (hit) begin
                        sel_d   = hit_idx;
                        err_d   = 1'b0;
                        state_d = ACCESS;
                    end else begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = RESP;
                    end
                end
            end
            ACCESS: begin
                // An ack in the final counted cycle takes priority over the
                // timeout.
                if (ack_sel) begin
                    rdata_d = write_q ? '0 : rdata_sel;
                    err_d   = 1'b0;
                    state_d = RESP;
                end
`ifdef BUS_FABRIC_TIMEOUT_EN
                else if (cnt_q == WAIT_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q <= IDLE;
            sel_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
`ifdef BUS_FABRIC_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
`ifdef BUS_FABRIC_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Outputs come only from state and registers, so no master input
    // reaches an output combinationally. The shared slave bus is forced to
    // zero outside ACCESS.
    always_comb begin
        sreq = '0;
        if (state_q == ACCESS) begin
            sreq[sel_q] = 1'b1;
        end
    end

    assign swrite = (state_q == ACCESS) & write_q;
    assign saddr  = (state_q == ACCESS) ? addr_q : '0;
    assign swdata = (state_q == ACCESS) ? wdata_q : '0;
    assign mready = (state_q == RESP);
    assign merr   = (state_q == RESP) & err_q;
    assign mrdata = (state_q == RESP) ? rdata_q : '0;

endmodule

// File: tb/tb_bus_fabric.sv
// Testbench for bus_fabric with the default three-slave address map.
module tb_bus_fabric;

   localparam int NSLAVE  = 3;
   localparam int AW      = 32;
   localparam int DW      = 32;
   localparam int TIMEOUT = 15;
   localparam int MAX_CYC = 40;

   localparam logic [NSLAVE*DW-1:0] RD_BACKGROUND = {32'hCCCC_0002, 32'hCCCC_0001, 32'hCCCC_0000};

   logic                 clock = 1'b0;
   logic                 nreset = 1'b0;
   logic                 mreq = 1'b0;
   logic                 mwrite = 1'b0;
   logic [AW-1:0]        maddr = '0;
   logic [DW-1:0]        mwdata = '0;
   logic                 mready;
   logic [DW-1:0]        mrdata;
   logic                 merr;
   logic [NSLAVE-1:0]    sreq;
   logic                 swrite;
   logic [AW-1:0]        saddr;
   logic [DW-1:0]        swdata;
   logic [NSLAVE-1:0]    sack = '0;
   logic [NSLAVE*DW-1:0] srdata = RD_BACKGROUND;

   typedef struct {
      logic              write;
      logic [31:0]       addr;
      logic [31:0]       wdata;
      int                ackDelay;
      logic [2:0]        stray;
      logic [31:0]       rdata;
      logic [2:0]        expSreq;
      logic              expErr;
      int                expLatency;
      int                expSreqCycles;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   vec_t vecs[$];
   exp_t expQ[$];
   int   checks = 0;
   int   failures = 0;

   // Free-running 10-unit clock.
   always #5 clock = ~clock;

   bus_fabric #(
      .NSLAVE(NSLAVE),
      .AW(AW),
      .DW(DW),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clock(clock),
      .nreset(nreset),
      .mreq(mreq),
      .mwrite(mwrite),
      .maddr(maddr),
      .mwdata(mwdata),
      .mready(mready),
      .mrdata(mrdata),
      .merr(merr),
      .sreq(sreq),
      .swrite(swrite),
      .saddr(saddr),
      .swdata(swdata),
      .sack(sack),
      .srdata(srdata)
   );

   // Single comparison point; every failed comparison prints one FAIL line.
   task automatic checkValue(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Pops the oldest expected response and compares it with the DUT output.
   task automatic checkOutput(input string tag);
      exp_t e;
      checkValue({tag, "_scoreboard_nonempty"}, expQ.size() == 0, 1'b0);
      if (expQ.size() != 0) begin
         e = expQ.pop_front();
         checkValue({tag, "_mrdata"}, mrdata, e.rdata);
         checkValue({tag, "_merr"}, merr, e.err);
      end
   endtask

   function automatic vec_t mkVec(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                  input int ackDelay, input logic [2:0] stray, input logic [31:0] rdata,
                                  input logic [2:0] expSreq, input logic expErr,
                                  input int expLatency, input int expSreqCycles);
      vec_t v;
      v.write = wr;
      v.addr = addr;
      v.wdata = wdata;
      v.ackDelay = ackDelay;
      v.stray = stray;
      v.rdata = rdata;
      v.expSreq = expSreq;
      v.expErr = expErr;
      v.expLatency = expLatency;
      v.expSreqCycles = expSreqCycles;
      return v;
   endfunction

   task automatic pulseReset();
      mreq = 1'b0;
      sack = '0;
      nreset = 1'b0;
      #3;
      nreset = 1'b1;
   endtask

   // Drives one transaction, plays the addressed slave and checks the bus
   // and the response timing.
   task automatic applyStimulus(input int idx, input vec_t v);
      logic [NSLAVE*DW-1:0] rd;
      exp_t e;
      int cyc;
      int sreqCycles;
      int waits;
      logic busOk;
      string tag;
      tag = $sformatf("vec%0d", idx);
      rd = RD_BACKGROUND;
      for (int i = 0; i < NSLAVE; i++) begin
         if (v.expSreq[i]) rd[i*DW +: DW] = v.rdata;
      end
      srdata = rd;
      @(negedge clock);
      mreq = 1'b1;
      mwrite = v.write;
      maddr = v.addr;
      mwdata = v.wdata;
      e.rdata = (v.write || v.expErr) ? 32'h0 : v.rdata;
      e.err = v.expErr;
      expQ.push_back(e);
      @(negedge clock);
      mreq = 1'b0;
      mwrite = 1'b0;
      maddr = '0;
      mwdata = '0;
      cyc = 1;
      sreqCycles = 0;
      waits = 0;
      busOk = 1'b1;
      while (!mready && cyc <= MAX_CYC) begin
         if (sreq != '0) begin
            sreqCycles++;
            if (sreq !== v.expSreq || swrite !== v.write || saddr !== v.addr || swdata !== v.wdata)
               busOk = 1'b0;
            if (waits == v.ackDelay) sack = v.expSreq;
            else sack = v.stray;
            waits++;
         end else begin
            busOk = 1'b0;
         end
         @(negedge clock);
         sack = '0;
         cyc++;
      end
      if (!mready) begin
         checkValue({tag, "_response_seen"}, mready, 1'b1);
         expQ.delete();
         pulseReset();
         return;
      end
      checkOutput(tag);
      checkValue({tag, "_latency"}, cyc, v.expLatency);
      checkValue({tag, "_sreq_cycles"}, sreqCycles, v.expSreqCycles);
      checkValue({tag, "_slave_bus"}, busOk, 1'b1);
      checkValue({tag, "_bus_idle_in_resp"}, {sreq, swrite, saddr, swdata}, '0);
      @(negedge clock);
      checkValue({tag, "_mready_one_cycle"}, mready, 1'b0);
   endtask

   initial begin
      int pulses;
      int times[$];

      // Default map: slave0 0..206799, slave1 206800..411699, slave2 411700.
      vecs.push_back(mkVec(1'b0, 32'd206800, 32'h0, 0, 3'b000, 32'hDEADBEEF, 3'b010, 1'b0, 2, 1));
      vecs.push_back(mkVec(1'b1, 32'd411700, 32'h5, 3, 3'b000, 32'h1234_5678, 3'b100, 1'b0, 5, 4));
      vecs.push_back(mkVec(1'b0, 32'd411701, 32'h0, -1, 3'b000, 32'h0, 3'b000, 1'b1, 1, 0));
      vecs.push_back(mkVec(1'b1, 32'hFFFF_FFFF, 32'h9, -1, 3'b000, 32'h0, 3'b000, 1'b1, 1, 0));
      vecs.push_back(mkVec(1'b0, 32'd206799, 32'h0, 1, 3'b010, 32'hA5A5_0001, 3'b001, 1'b0, 3, 2));
      vecs.push_back(mkVec(1'b0, 32'd0, 32'h0, 0, 3'b000, 32'h0BAD_F00D, 3'b001, 1'b0, 2, 1));
      vecs.push_back(mkVec(1'b0, 32'd411699, 32'h0, 2, 3'b101, 32'h5555_AAAA, 3'b010, 1'b0, 4, 3));
      vecs.push_back(mkVec(1'b1, 32'd206800, 32'hCAFE, 0, 3'b000, 32'h7777_7777, 3'b010, 1'b0, 2, 1));
`ifdef BUS_FABRIC_TIMEOUT_EN
      vecs.push_back(mkVec(1'b0, 32'd100, 32'h0, -1, 3'b000, 32'h3333_3333, 3'b001, 1'b1, 16, 15));
      vecs.push_back(mkVec(1'b0, 32'd100, 32'h0, 14, 3'b000, 32'h4444_4444, 3'b001, 1'b0, 16, 15));
`else
      vecs.push_back(mkVec(1'b0, 32'd100, 32'h0, 20, 3'b000, 32'h4444_4444, 3'b001, 1'b0, 22, 21));
`endif

      // Reset state.
      #12;
      checkValue("reset_outputs", {mready, merr, mrdata, sreq, swrite, saddr, swdata}, '0);
      @(negedge clock);
      nreset = 1'b1;

      for (int i = 0; i < vecs.size(); i++) applyStimulus(i, vecs[i]);

      // Asynchronous reset while a stalled write is in ACCESS.
      @(negedge clock);
      mreq = 1'b1;
      mwrite = 1'b1;
      maddr = 32'd1000;
      mwdata = 32'h77;
      @(negedge clock);
      mreq = 1'b0;
      @(negedge clock);
      @(negedge clock);
      checkValue("midop_sreq_before_reset", {sreq, swrite, swdata}, {3'b001, 1'b1, 32'h77});
      #2;
      nreset = 1'b0;
      #1;
      checkValue("midop_async_reset_outputs", {mready, merr, mrdata, sreq, swrite, saddr, swdata}, '0);
      @(negedge clock);
      nreset = 1'b1;
      mwrite = 1'b0;
      maddr = '0;
      mwdata = '0;
      pulses = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clock);
         if (mready || sreq != '0) pulses++;
      end
      checkValue("midop_no_response_after_reset", pulses, 0);
      applyStimulus(100, vecs[0]);

      // Held mreq with an always-acking slave1: back-to-back transactions.
      srdata = {32'hCCCC_0002, 32'h0B2B_0B2B, 32'hCCCC_0000};
      sack = 3'b010;
      @(negedge clock);
      mreq = 1'b1;
      mwrite = 1'b0;
      maddr = 32'd206900;
      for (int k = 0; k < 3; k++) expQ.push_back('{rdata: 32'h0B2B_0B2B, err: 1'b0});
      for (int k = 1; k <= 12; k++) begin
         @(negedge clock);
         if (mready) begin
            checkOutput($sformatf("b2b%0d", times.size()));
            times.push_back(k);
            if (times.size() == 3) mreq = 1'b0;
         end
      end
      mreq = 1'b0;
      sack = '0;
      checkValue("b2b_response_count", times.size(), 3);
      if (times.size() >= 3) begin
         checkValue("b2b_first_latency", times[0], 2);
         checkValue("b2b_spacing_1", times[1] - times[0], 3);
         checkValue("b2b_spacing_2", times[2] - times[1], 3);
      end
      checkValue("scoreboard_drained", expQ.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
